// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and types shared by the fetch front end.
//   FETCH_W  : instruction slots per fetch line
//   INSTR_W  : bits per instruction slot
//   PKT_W    : bits of instruction data per fetch line
//   LINE_OFF : byte-offset bits within one fetch line
//   ADDR_W   : byte-address width carried in a buffered packet
//   fetch_pkt_t : one buffered packet {instr, mask, pc}
//   slot_mask() : valid-slot mask for a line entered at a given slot
package fetch_pkg;

  localparam int FETCH_W  = 4;
  localparam int INSTR_W  = 32;
  localparam int PKT_W    = 128;
  localparam int LINE_OFF = 4;
  localparam int ADDR_W   = 12;

  typedef struct packed {
    logic [PKT_W-1:0]   instr;
    logic [FETCH_W-1:0] mask;
    logic [ADDR_W-1:0]  pc;
  } fetch_pkt_t;

  // Slots at or above the entry slot are live; earlier slots precede the
  // fetch target and must not reach decode.
  function automatic logic [FETCH_W-1:0] slot_mask(input logic [1:0] first_slot);
    return 4'b1111 << first_slot;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-cache request/response and decode handshake
// signals of the fetch stage.
//   o_IcacheReq/o_IcacheAddr : line request and line-aligned address
//   i_IcacheData             : line data, one cycle after the request
//   i_redirect/i_redirectPC  : flush and restart fetch at a new PC
//   o_valid/o_instr/o_mask/o_pc : head packet towards decode
//   i_ready                  : decode accepts the head packet
// Modport master is the fetch unit; modport slave is its environment.
interface fetch_unit_if #(
  parameter int WIDTH = 12
);

  logic                      o_IcacheReq;
  logic [WIDTH-1:0]          o_IcacheAddr;
  logic [fetch_pkg::PKT_W-1:0]   i_IcacheData;
  logic                      i_redirect;
  logic [WIDTH-1:0]          i_redirectPC;
  logic                      o_valid;
  logic [fetch_pkg::PKT_W-1:0]   o_instr;
  logic [fetch_pkg::FETCH_W-1:0] o_mask;
  logic [WIDTH-1:0]          o_pc;
  logic                      i_ready;

  modport master (
    output o_IcacheReq, o_IcacheAddr, o_valid, o_instr, o_mask, o_pc,
    input  i_IcacheData, i_redirect, i_redirectPC, i_ready
  );

  modport slave (
    input  o_IcacheReq, o_IcacheAddr, o_valid, o_instr, o_mask, o_pc,
    output i_IcacheData, i_redirect, i_redirectPC, i_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush for buffered fetch packets.
//   clk, rst     : clock, synchronous active-high reset
//   flush        : empties the FIFO, overriding push and pop
//   push, din    : write an entry (never issued when full)
//   pop, dout    : remove the head entry (never issued when empty)
//   count        : current occupancy 0..DEPTH
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pointer and occupancy tracking; flush behaves like reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch stage. Generates the fetch PC, requests 4-instruction
// lines from the I-cache, buffers returned packets and presents them to
// decode over a valid/ready handshake. A redirect flushes the buffer,
// kills the in-flight response and restarts fetch at the new PC.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : fetch_unit_if.master (I-cache, redirect, decode signals)
// Optional feature macro FETCH_BYPASS_EN: a live response is shown to
// decode in its arrival cycle when the buffer is empty.
// WIDTH must equal fetch_pkg::ADDR_W, the pc width of a buffered packet.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = ADDR_W,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   fetch_pc;
  logic [WIDTH-1:0]   line_base;
  logic               inflight;
  logic [FETCH_W-1:0] inf_mask;
  logic [WIDTH-1:0]   inf_base;
  logic [CW-1:0]      fifo_count;
  fetch_pkt_t         push_pkt;
  fetch_pkt_t         head_pkt;
  logic               credit;
  logic               req;
  logic               live;
  logic               head_valid;
  logic               push;
  logic               pop;

  assign line_base = {fetch_pc[WIDTH-1:LINE_OFF], LINE_OFF'(0)};

  // Credit uses registered state only, so a pop frees a slot one cycle later.
  assign credit = ({1'b0, fetch_count_ext(fifo_count)} + {{CW{1'b0}}, inflight}) < (CW+1)'(DEPTH);

  function automatic logic [CW-1:0] fetch_count_ext(input logic [CW-1:0] c);
    return c;
  endfunction

  assign req  = credit && !bus.i_redirect && !i_rst;
  assign live = inflight && !bus.i_redirect;

  assign bus.o_IcacheReq  = req;
  assign bus.o_IcacheAddr = line_base;

  assign push_pkt   = '{instr: bus.i_IcacheData, mask: inf_mask, pc: inf_base};
  assign head_valid = (fifo_count != '0);
  assign pop        = head_valid && bus.i_ready;

`ifdef FETCH_BYPASS_EN
  logic bypass;

  // An arriving packet skips the empty buffer; it is only stored if decode
  // does not take it straight away.
  assign bypass      = !head_valid && live;
  assign bus.o_valid = head_valid || bypass;
  assign bus.o_instr = bypass ? push_pkt.instr : head_pkt.instr;
  assign bus.o_mask  = bypass ? push_pkt.mask  : head_pkt.mask;
  assign bus.o_pc    = bypass ? push_pkt.pc    : head_pkt.pc;
  assign push        = live && !(bypass && bus.i_ready);
`else
  assign bus.o_valid = head_valid;
  assign bus.o_instr = head_pkt.instr;
  assign bus.o_mask  = head_pkt.mask;
  assign bus.o_pc    = head_pkt.pc;
  assign push        = live;
`endif

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(fetch_pkt_t))
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .flush (bus.i_redirect),
    .push  (push),
    .din   (push_pkt),
    .pop   (pop),
    .dout  (head_pkt),
    .count (fifo_count)
  );

  // PC and in-flight tracking. A response always lands the cycle after its
  // request, so inflight simply follows req unless a redirect kills it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      inf_mask <= '0;
      inf_base <= '0;
    end else if (bus.i_redirect) begin
      fetch_pc <= {bus.i_redirectPC[WIDTH-1:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= req;
      if (req) begin
        inf_mask <= slot_mask(fetch_pc[3:2]);
        inf_base <= line_base;
        fetch_pc <= line_base + WIDTH'(16);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
// (WIDTH=12, DEPTH=4, RESET_PC=0x008). The bench plays the I-cache,
// returning a recognisable line one cycle after each request.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int WIDTH = 12;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   passed   = 0;
  int   failed   = 0;
  int   reqCount = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.WIDTH(WIDTH)) bus ();

  fetch_unit #(
    .WIDTH    (WIDTH),
    .DEPTH    (4),
    .RESET_PC (12'h008)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Instruction word k of the line at address a: C0DE, address, slot.
  function automatic logic [127:0] lineData(input logic [11:0] a);
    logic [127:0] d;
    for (int k = 0; k < 4; k++) d[32*k +: 32] = {16'hC0DE, a, 4'(k)};
    return d;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rdy, input logic redir, input logic [11:0] rpc);
    rst              = r;
    bus.i_ready      = rdy;
    bus.i_redirect   = redir;
    bus.i_redirectPC = rpc;
    #1;
  endtask

  // One clock: sample the request, cross the edge, answer with line data.
  task automatic tick();
    logic        r;
    logic [11:0] a;
    #1;
    r = bus.o_IcacheReq;
    a = bus.o_IcacheAddr;
    if (r) reqCount++;
    @(posedge clk);
    #1;
    bus.i_IcacheData = r ? lineData(a) : '0;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.i_IcacheData = '0;
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h000);
    $display("[TB] reset state");
    checkOutput("rst_valid", bus.o_valid, 1'b0);
    checkOutput("rst_req", bus.o_IcacheReq, 1'b1);
    checkOutput("rst_addr", bus.o_IcacheAddr, 12'h000);
    checkOutput("rst_count", dut.fifo_count, 3'd0);

`ifdef FETCH_BYPASS_EN
    $display("[TB] bypass from empty buffer");
    tick();
    checkOutput("byp_valid", bus.o_valid, 1'b1);
    checkOutput("byp_mask", bus.o_mask, 4'b1100);
    checkOutput("byp_pc", bus.o_pc, 12'h000);
    checkOutput("byp_instr", bus.o_instr, lineData(12'h000));
    checkOutput("byp_count0", dut.fifo_count, 3'd0);
    tick();
    checkOutput("byp_count1", dut.fifo_count, 3'd0);
    checkOutput("byp_valid2", bus.o_valid, 1'b1);
    checkOutput("byp_pc2", bus.o_pc, 12'h010);
    checkOutput("byp_mask2", bus.o_mask, 4'b1111);
`else
    $display("[TB] first fetch from RESET_PC");
    tick();
    checkOutput("e1_valid", bus.o_valid, 1'b0);
    checkOutput("e1_addr", bus.o_IcacheAddr, 12'h010);
    tick();
    checkOutput("pkt0_valid", bus.o_valid, 1'b1);
    checkOutput("pkt0_mask", bus.o_mask, 4'b1100);
    checkOutput("pkt0_pc", bus.o_pc, 12'h000);
    checkOutput("pkt0_instr", bus.o_instr, lineData(12'h000));
    tick();
    checkOutput("pkt1_pc", bus.o_pc, 12'h010);
    checkOutput("pkt1_mask", bus.o_mask, 4'b1111);
    checkOutput("pkt1_instr", bus.o_instr, lineData(12'h010));

    $display("[TB] backpressure");
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);
    reqCount = 0;
    repeat (10) tick();
    checkOutput("bp_reqs", 128'(reqCount), 128'd4);
    checkOutput("bp_count", dut.fifo_count, 3'd4);
    checkOutput("bp_req_off", bus.o_IcacheReq, 1'b0);
    checkOutput("bp_head_pc", bus.o_pc, 12'h000);
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);
    checkOutput("bp_req_back", bus.o_IcacheReq, 1'b1);
    checkOutput("bp_req_addr", bus.o_IcacheAddr, 12'h040);
    checkOutput("bp_head_pc2", bus.o_pc, 12'h010);
    checkOutput("bp_count3", dut.fifo_count, 3'd3);

    $display("[TB] redirect with buffered and in-flight packets");
    tick();
    checkOutput("rd_count_pre", dut.fifo_count, 3'd3);
    applyStimulus(1'b0, 1'b0, 1'b1, 12'h124);
    checkOutput("rd_no_req", bus.o_IcacheReq, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h000);
    checkOutput("rd_valid0", bus.o_valid, 1'b0);
    checkOutput("rd_count0", dut.fifo_count, 3'd0);
    checkOutput("rd_addr", bus.o_IcacheAddr, 12'h120);
    tick();
    checkOutput("rd_killed", dut.fifo_count, 3'd0);
    tick();
    checkOutput("rd_pkt_valid", bus.o_valid, 1'b1);
    checkOutput("rd_pkt_pc", bus.o_pc, 12'h120);
    checkOutput("rd_pkt_mask", bus.o_mask, 4'b1110);
    checkOutput("rd_pkt_instr", bus.o_instr, lineData(12'h120));

    $display("[TB] address wrap");
    applyStimulus(1'b0, 1'b1, 1'b1, 12'hFF0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h000);
    checkOutput("wrap_addr0", bus.o_IcacheAddr, 12'hFF0);
    tick();
    checkOutput("wrap_addr1", bus.o_IcacheAddr, 12'h000);
    tick();
    checkOutput("wrap_pc", bus.o_pc, 12'hFF0);
    checkOutput("wrap_mask", bus.o_mask, 4'b1111);

    $display("[TB] redirect with handshake on the same edge");
    applyStimulus(1'b0, 1'b1, 1'b1, 12'h200);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h000);
    checkOutput("rh_valid0", bus.o_valid, 1'b0);
    checkOutput("rh_count0", dut.fifo_count, 3'd0);
    tick();
    checkOutput("rh_valid1", bus.o_valid, 1'b0);
    tick();
    checkOutput("rh_pkt_pc", bus.o_pc, 12'h200);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 12'h000);
    checkOutput("mr_valid", bus.o_valid, 1'b0);
    checkOutput("mr_addr", bus.o_IcacheAddr, 12'h000);
    checkOutput("mr_req", bus.o_IcacheReq, 1'b1);
    tick();
    tick();
    checkOutput("mr_pkt_pc", bus.o_pc, 12'h000);
    checkOutput("mr_pkt_mask", bus.o_mask, 4'b1100);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
